// File: rtl/sparcy_mem_pkg.sv
// Shared constants and types for the memory-access stage.
// Covers SPARC op3 codes, the bubble encoding, the access-size and FSM enums, and decode helpers.
package sparcy_mem_pkg;

    localparam logic [1:0] OP_MEM     = 2'b11;
    localparam logic [1:0] BUBBLE_OP  = 2'b00;
    localparam logic [2:0] BUBBLE_OP2 = 3'b100;

    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDD  = 6'b000011;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;
    localparam logic [5:0] OP3_STD  = 6'b000111;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;
    localparam logic [5:0] OP3_LDX  = 6'b001011;
    localparam logic [5:0] OP3_STX  = 6'b001110;

    typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} accessSizeT;
    typedef enum logic {IDLE, WAIT} stateT;

    function automatic logic isMemOp3(input logic [5:0] op3);
        case (op3)
            OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_ST, OP3_STB, OP3_STH,
            OP3_STD, OP3_LDSB, OP3_LDSH, OP3_LDX, OP3_STX: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic accessSizeT op3Size(input logic [5:0] op3);
        case (op3)
            OP3_LDUB, OP3_LDSB, OP3_STB: return BYTE;
            OP3_LDUH, OP3_LDSH, OP3_STH: return HALF;
            OP3_LD, OP3_ST:              return WORD;
            default:                     return DWORD;
        endcase
    endfunction

    function automatic logic isSignedLoad(input logic [5:0] op3);
        return (op3 == OP3_LDSB) || (op3 == OP3_LDSH) || (op3 == OP3_LD);
    endfunction

    function automatic logic isStoreOp3(input logic [5:0] op3);
        return (op3 == OP3_ST) || (op3 == OP3_STB) || (op3 == OP3_STH) ||
               (op3 == OP3_STD) || (op3 == OP3_STX);
    endfunction

    // Index of the last lane of an access relative to its first lane (byte count minus one).
    function automatic logic [2:0] lastLane(input accessSizeT size);
        case (size)
            BYTE:    return 3'd0;
            HALF:    return 3'd1;
            WORD:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Right-justifies the addressed big-endian lanes of a read doubleword and extends them to 64 bits.
module load_align
    import sparcy_mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  accessSizeT  size,
    input  logic        isSigned,
    output logic [63:0] result
);

    logic [2:0]  shiftLanes;
    logic [63:0] shifted;

    always_comb begin
        shiftLanes = 3'd7 - offset - lastLane(size);
        shifted    = rdata >> {shiftLanes, 3'b000};
        result     = shifted;
        case (size)
            BYTE:    result = {{56{isSigned & shifted[7]}},  shifted[7:0]};
            HALF:    result = {{48{isSigned & shifted[15]}}, shifted[15:0]};
            WORD:    result = {{32{isSigned & shifted[31]}}, shifted[31:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: decodes memory ops, runs one outstanding dmem transaction,
// stalls upstream while it is pending and emits bubbles until the ack arrives.
module mem_stage
    import sparcy_mem_pkg::*;
#(
    parameter int ADDR_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Mem_valid_in,
    input  logic [63:0]          Mem_alures_in,
    input  logic [63:0]          Mem_store_data_in,
    input  logic [4:0]           Mem_regD_in,
    input  logic [1:0]           Mem_op_in,
    input  logic [2:0]           Mem_op2_in,
    input  logic [5:0]           Mem_op3_in,
    output logic [63:0]          Mem_alures_out,
    output logic [63:0]          Mem_load_data_out,
    output logic [4:0]           Mem_regD_out,
    output logic [1:0]           Mem_op_out,
    output logic [2:0]           Mem_op2_out,
    output logic [5:0]           Mem_op3_out,
    output logic                 Mem_stall,
    output logic                 Mem_trap,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [7:0]           dmem_be,
    output logic [63:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [63:0]          dmem_rdata
);

    stateT       state, nextState;
    logic        capture;
    logic [63:0] holdAlures, holdStoreData;
    logic [4:0]  holdRegD;
    logic [1:0]  holdOp;
    logic [2:0]  holdOp2;
    logic [5:0]  holdOp3;

    logic        waiting, activeValid, isMem, isStore, misaligned;
    logic [63:0] activeAlures, activeStoreData, loadData;
    logic [4:0]  activeRegD;
    logic [1:0]  activeOp;
    logic [2:0]  activeOp2, offset, laneShift;
    logic [5:0]  activeOp3;
    logic [7:0]  laneMask, reqBe;
    logic [63:0] reqWdata;
    accessSizeT  size;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            holdAlures    <= '0;
            holdStoreData <= '0;
            holdRegD      <= '0;
            holdOp        <= '0;
            holdOp2       <= '0;
            holdOp3       <= '0;
        end else begin
            state <= nextState;
            if (capture) begin
                holdAlures    <= Mem_alures_in;
                holdStoreData <= Mem_store_data_in;
                holdRegD      <= Mem_regD_in;
                holdOp        <= Mem_op_in;
                holdOp2       <= Mem_op2_in;
                holdOp3       <= Mem_op3_in;
            end
        end
    end

    // Once a request is outstanding, every dmem field is derived from the held copy of the instruction.
    always_comb begin
        waiting         = (state == WAIT);
        activeValid     = waiting | Mem_valid_in;
        activeAlures    = waiting ? holdAlures    : Mem_alures_in;
        activeStoreData = waiting ? holdStoreData : Mem_store_data_in;
        activeRegD      = waiting ? holdRegD      : Mem_regD_in;
        activeOp        = waiting ? holdOp        : Mem_op_in;
        activeOp2       = waiting ? holdOp2       : Mem_op2_in;
        activeOp3       = waiting ? holdOp3       : Mem_op3_in;

        isMem   = activeValid && (activeOp == OP_MEM) && isMemOp3(activeOp3);
        isStore = isStoreOp3(activeOp3);
        size    = op3Size(activeOp3);
        offset  = activeAlures[2:0];

        case (size)
            HALF:    misaligned = offset[0];
            WORD:    misaligned = |offset[1:0];
            DWORD:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase

        case (size)
            BYTE:    laneMask = 8'h01;
            HALF:    laneMask = 8'h03;
            WORD:    laneMask = 8'h0F;
            default: laneMask = 8'hFF;
        endcase
        laneShift = 3'd7 - offset - lastLane(size);
        reqBe     = laneMask << laneShift;

        case (size)
            BYTE:    reqWdata = {8{activeStoreData[7:0]}};
            HALF:    reqWdata = {4{activeStoreData[15:0]}};
            WORD:    reqWdata = {2{activeStoreData[31:0]}};
            default: reqWdata = activeStoreData;
        endcase
    end

    load_align uLoadAlign (
        .rdata    (dmem_rdata),
        .offset   (offset),
        .size     (size),
        .isSigned (isSignedLoad(activeOp3)),
        .result   (loadData)
    );

    // Everything defaults to the bubble with the memory port idle; reset holds it there.
    always_comb begin
        nextState         = state;
        capture           = 1'b0;
        Mem_alures_out    = '0;
        Mem_load_data_out = '0;
        Mem_regD_out      = '0;
        Mem_op_out        = BUBBLE_OP;
        Mem_op2_out       = BUBBLE_OP2;
        Mem_op3_out       = '0;
        Mem_stall         = 1'b0;
        Mem_trap          = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_addr         = '0;
        dmem_be           = '0;
        dmem_wdata        = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (Mem_valid_in && !isMem) begin
                        Mem_alures_out = Mem_alures_in;
                        Mem_regD_out   = Mem_regD_in;
                        Mem_op_out     = Mem_op_in;
                        Mem_op2_out    = Mem_op2_in;
                        Mem_op3_out    = Mem_op3_in;
                    end else if (isMem && misaligned) begin
                        Mem_trap = 1'b1;
                    end else if (isMem) begin
                        dmem_req   = 1'b1;
                        dmem_we    = isStore;
                        dmem_addr  = {activeAlures[ADDR_SIZE-1:3], 3'b000};
                        dmem_be    = reqBe;
                        dmem_wdata = isStore ? reqWdata : '0;
                        Mem_stall  = 1'b1;
                        capture    = 1'b1;
                        nextState  = WAIT;
                    end
                end
                WAIT: begin
                    dmem_req   = 1'b1;
                    dmem_we    = isStore;
                    dmem_addr  = {activeAlures[ADDR_SIZE-1:3], 3'b000};
                    dmem_be    = reqBe;
                    dmem_wdata = isStore ? reqWdata : '0;
                    if (dmem_ack) begin
                        Mem_alures_out    = activeAlures;
                        Mem_load_data_out = isStore ? '0 : loadData;
                        Mem_regD_out      = activeRegD;
                        Mem_op_out        = activeOp;
                        Mem_op2_out       = activeOp2;
                        Mem_op3_out       = activeOp3;
                        nextState         = IDLE;
                    end else begin
                        Mem_stall = 1'b1;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the integer pipeline, between the Ex/Mem pipeline register and the Mem/WB pipeline register. It decodes SPARC memory-format instructions, aligns and byte-enables stores, and sign- or zero-extends loads. It runs a single-outstanding request/acknowledge transaction with the data memory. It stalls upstream while a transaction is pending and drives a no-op bubble into Mem/WB until the transaction completes.

## Interface
- ADDR_SIZE, 64, data-memory address width; the data path is fixed at 64 bits
- clk  in  1  pipeline clock; single clock domain
- reset  in  1  synchronous, active-high reset
- Mem_valid_in  in  1  Ex/Mem holds a real instruction
- Mem_alures_in  in  64  ALU result; effective address for memory ops
- Mem_store_data_in  in  64  rd source value for stores
- Mem_regD_in  in  5  destination register
- Mem_op_in / Mem_op2_in / Mem_op3_in  in  2/3/6  SPARC op, op2, op3 fields
- Mem_alures_out  out  64  to Mem/WB
- Mem_load_data_out  out  64  extended load data to Mem/WB
- Mem_regD_out / Mem_op_out / Mem_op2_out / Mem_op3_out  out  5/2/3/6  to Mem/WB
- Mem_stall  out  1  freeze Ex/Mem and all earlier stages
- Mem_trap  out  1  one-cycle pulse on a misaligned access
- dmem_req  out  1  request; held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_SIZE  address; low 3 bits are forced to 0
- dmem_be  out  8  byte enables; bit 7 = byte lane 63:56 (address offset 0, big-endian)
- dmem_wdata  out  64  lane-aligned store data
- dmem_ack  in  1  transaction complete; rdata valid this cycle
- dmem_rdata  in  64  read doubleword

## Operation
- Memory op: valid, op=2'b11, op3 in {LD 000000, LDUB 000001, LDUH 000010, LDD 000011, ST 000100, STB 000101, STH 000110, STD 000111, LDSB 001001, LDSH 001010, LDX 001011, STX 001110}.
- Access sizes: byte = B; half = H; word = LD/ST; doubleword = LDD/STD/LDX/STX.
- Any other op with valid=1 passes straight through (combinational), with no stall.
- Any input with valid=0 produces a bubble.
- Bubble encoding: op=00, op2=100, op3=0, regD=0, alures=0, load_data=0.
- Misalignment rules: half needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0.
- Misaligned access: no request is issued, Mem_trap pulses for one cycle, a bubble is output, and there is no stall.
- Byte lanes use offset k=addr[2:0]; the lane for offset k occupies bits 63-8k : 56-8k.
- Store data: the low byte/half/word is replicated across all lanes; be selects the addressed lanes.
- Loads: the selected lanes are right-justified, then sign-extended for LDSB/LDSH/LD. LD is sign-extended to 64 bits (V9 LDSW semantics); LDUB/LDUH are zero-extended; doubleword loads pass through raw.
- FSM state IDLE:
  - Stays in IDLE for pass-through, bubble, or misaligned inputs.
  - On an aligned memory op: assert dmem_req combinationally from the inputs, capture all inputs into hold registers, assert Mem_stall, and go to WAIT.
- FSM state WAIT:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata come from the hold registers and are stable.
  - Without ack: Mem_stall=1 and the output is a bubble.
  - With ack: Mem_stall=0; outputs are the held fields plus formatted load data (0 for stores); go to IDLE.
- dmem_ack seen in IDLE is ignored.

## Timing
- Pass-through latency: 0 cycles.
- Minimum memory-op latency: 2 cycles (request in cycle N, earliest ack N+1). A back-to-back memory op may issue in the cycle after the ack.
- Mem_stall is high from the request cycle until, but not including, the ack cycle.
- While reset=1: state goes to IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, Mem_stall=0, Mem_trap=0; outputs are the bubble.
- Reset during WAIT abandons the transaction. The request drops in the reset cycle, and a later stray ack is ignored.
- Ack and a new memory op cannot coincide: the new op is not visible until the stall releases.

## Structure
- Package sparcy_mem_pkg holds:
  - op3 constants
  - the bubble encoding constants (op 00, op2 100)
  - the size enum (BYTE, HALF, WORD, DWORD)
  - the FSM state enum (IDLE, WAIT)
- Sub-module load_align: combinational; takes rdata, offset, size and signed flag, and returns the extended 64-bit value. The bench tests it standalone.

## Test plan
- LDUB, addr 0x1003, rdata 0x0011223344556677: be=0x10 → load_data 0x33; stall 1 cycle with ack at N+1.
- LDSH, addr 0x2006, rdata lanes 6–7 = 0x8001: load_data 0xFFFFFFFFFFFF8001.
- STH, addr 0x3002, store_data 0xBEEF: dmem_we=1, be=0x30, wdata 0xBEEFBEEFBEEFBEEF; output load_data 0.
- LD, addr 0x4002: Mem_trap pulse, dmem_req stays 0, bubble out, no stall.
- ack delayed 5 cycles: Mem_stall high for 5 cycles, dmem_addr stable, bubbles out, then one valid output.
- reset asserted during WAIT, followed by a stray ack: dmem_req=0 in the reset cycle, bubble out, stray ack produces no output.
